// File: rtl/idct2d_seq.sv
// idct2d_seq: 8x8 inverse DCT; row pass then column pass through one shared 1-D unit.
// Optional build macro IDCT2D_LEVEL_SHIFT_EN: column results +128, clamped to [0,255].
//
// state | meaning
// LOAD  | accept 8 coefficient rows into the buffer
// ROW   | 1-D IDCT of buffer row cnt, written back in place
// COL   | 1-D IDCT of buffer column cnt, written back in place
// DRAIN | stream buffer row cnt to the sink
module idct2d_seq #(
   parameter int N    = 16,
   parameter int FRAC = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8*N-1:0] in_row,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [8*N-1:0] out_row
);

   typedef enum logic [1:0] {LOAD, ROW, COL, DRAIN} state_t;

   localparam int SW = N + FRAC + 4;
   localparam logic signed [SW-1:0] RND  = SW'(2 ** (FRAC - 1));
   localparam logic signed [SW-1:0] MAXV = SW'((2 ** (N - 1)) - 1);
   localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

   // K[n][k] = round(2^12 * c(k)/2 * cos((2n+1)k*pi/16)); table is tabulated for FRAC=12
   localparam int KT [8][8] = '{
      '{1448,  2009,  1892,  1703,  1448,  1138,   784,   400},
      '{1448,  1703,   784,  -400, -1448, -2009, -1892, -1138},
      '{1448,  1138,  -784, -2009, -1448,   400,  1892,  1703},
      '{1448,   400, -1892, -1138,  1448,  1703,  -784, -2009},
      '{1448,  -400, -1892,  1138,  1448, -1703,  -784,  2009},
      '{1448, -1138,  -784,  2009, -1448,  -400,  1892, -1703},
      '{1448, -1703,   784,   400, -1448,  2009, -1892,  1138},
      '{1448, -2009,  1892, -1703,  1448, -1138,   784,  -400}
   };

   function automatic logic [8*N-1:0] idct1d(input logic [8*N-1:0] x);
      logic signed [SW-1:0] acc;
      logic signed [SW-1:0] sh;
      logic [8*N-1:0]       y;
      y = '0;
      for (int n = 0; n < 8; n++) begin
         acc = RND;
         for (int k = 0; k < 8; k++) begin
            acc = acc + SW'($signed(x[k*N +: N])) * SW'(KT[n][k]);
         end
         sh = acc >>> FRAC;
         if (sh > MAXV) begin
            sh = MAXV;
         end else if (sh < MINV) begin
            sh = MINV;
         end
         y[n*N +: N] = sh[N-1:0];
      end
      return y;
   endfunction

`ifdef IDCT2D_LEVEL_SHIFT_EN
   localparam logic signed [SW-1:0] PIX_MAX = SW'(255);

   function automatic logic [8*N-1:0] lshift(input logic [8*N-1:0] x);
      logic signed [SW-1:0] t;
      logic [8*N-1:0]       y;
      y = '0;
      for (int n = 0; n < 8; n++) begin
         t = SW'($signed(x[n*N +: N])) + SW'(128);
         if (t < 0) begin
            t = '0;
         end else if (t > PIX_MAX) begin
            t = PIX_MAX;
         end
         y[n*N +: N] = t[N-1:0];
      end
      return y;
   endfunction
`endif

   logic [N-1:0]   r_buf [8][8];
   state_t         r_state;
   state_t         w_state_nxt;
   logic [2:0]     r_cnt;
   logic [2:0]     w_cnt_nxt;
   logic           w_load_wr;
   logic [8*N-1:0] w_row_rd;
   logic [8*N-1:0] w_col_rd;
   logic [8*N-1:0] w_idct_in;
   logic [8*N-1:0] w_idct_out;
   logic [8*N-1:0] w_col_wr;

   always_comb begin
      w_row_rd = '0;
      w_col_rd = '0;
      for (int i = 0; i < 8; i++) begin
         w_row_rd[i*N +: N] = r_buf[r_cnt][i];
         w_col_rd[i*N +: N] = r_buf[i][r_cnt];
      end
   end

   assign w_idct_in  = (r_state == COL) ? w_col_rd : w_row_rd;
   assign w_idct_out = idct1d(w_idct_in);

`ifdef IDCT2D_LEVEL_SHIFT_EN
   assign w_col_wr = lshift(w_idct_out);
`else
   assign w_col_wr = w_idct_out;
`endif

   // buffer has no reset: its contents are always rewritten before being read
   always_ff @(posedge clk) begin
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (w_load_wr && (r_cnt == 3'(r))) begin
               r_buf[r][c] <= in_row[c*N +: N];
            end else if ((r_state == ROW) && (r_cnt == 3'(r))) begin
               r_buf[r][c] <= w_idct_out[c*N +: N];
            end else if ((r_state == COL) && (r_cnt == 3'(c))) begin
               r_buf[r][c] <= w_col_wr[r*N +: N];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LOAD;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // cnt wraps 7->0 through natural overflow, always together with a state change
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load_wr   = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_row     = '0;
      case (r_state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load_wr = 1'b1;
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  w_state_nxt = ROW;
               end
            end
         end
         ROW: begin
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               w_state_nxt = COL;
            end
         end
         COL: begin
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_row   = w_row_rd;
            if (out_ready) begin
               w_cnt_nxt = r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  w_state_nxt = LOAD;
               end
            end
         end
         default: begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
         end
      endcase
   end

endmodule
